// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory responder.
package instr_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_GNT    = 3'd1,
    ST_GRANT       = 3'd2,
    ST_WAIT_RVALID = 3'd3,
    ST_RVALID      = 3'd4
  } state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam int GNT_DELAY_MIN    = 0;
  localparam int GNT_DELAY_MAX    = 15;
  localparam int RVALID_DELAY_MIN = 1;
  localparam int RVALID_DELAY_MAX = 15;

  // Wide enough for the largest programmable delay.
  localparam int CNT_W = 4;

  // Keeps an out-of-range delay parameter inside what the counter can express.
  function automatic int clamp_delay(input int d, input int lo, input int hi);
    if (d < lo) return lo;
    if (d > hi) return hi;
    return d;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Program storage: one backdoor write port and one registered read port.
// Contents are deliberately not reset so a loaded program survives rst_n.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write and read share an edge; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Memory side of the instruction fetch handshake with programmable grant and
// rvalid latency, stall-driven wait states and an initiator protocol checker.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no transaction; samples req
// WAIT_GNT    | request seen, counting grant delay; stall freezes count
// GRANT       | one-cycle grant pulse; word index latched
// WAIT_RVALID | counting down to the data phase; stall ignored
// RVALID      | one-cycle rvalid pulse with rdata / rsp_err
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEM_DEPTH    = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    GNT_DELAY    = 0,
  parameter int                    RVALID_DELAY = 1,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA     = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         instr_req,
  input  logic [ADDR_WIDTH-1:0]        instr_addr,
  output logic                         instr_grant,
  output logic                         instr_rvalid,
  output logic [DATA_WIDTH-1:0]        instr_rdata,
  output logic                         rsp_err,
  input  logic                         stall,
  input  logic                         load_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_idx,
  input  logic [DATA_WIDTH-1:0]        load_data,
  output logic                         protocol_err,
  output logic [31:0]                  resp_count
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int GNT_D = clamp_delay(GNT_DELAY, GNT_DELAY_MIN, GNT_DELAY_MAX);
  localparam int RV_D  = clamp_delay(RVALID_DELAY, RVALID_DELAY_MIN, RVALID_DELAY_MAX);

  // A stalled first cycle does not count toward the grant delay, hence the
  // one-larger load value on the stall path.
  localparam logic [CNT_W-1:0] GNT_LD_STALL = CNT_W'(GNT_D);
  localparam logic [CNT_W-1:0] GNT_LD_RUN   = CNT_W'((GNT_D > 0) ? GNT_D - 1 : 0);
  localparam logic [CNT_W-1:0] RV_LD        = CNT_W'((RV_D > 1) ? RV_D - 2 : 0);
  localparam bit               GNT_NOW      = (GNT_D == 0);
  localparam bit               RV_NOW       = (RV_D == 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   oor_q;
  logic                   err_sel_q;
  logic                   have_data_q;
  logic                   grant_q;
  logic                   rvalid_q;
  logic                   rsp_err_q;
  logic                   perr_q;
  logic [31:0]            resp_count_q;

  logic [ADDR_WIDTH-1:0]  offset;
  logic [ADDR_WIDTH-1:0]  word;
  logic                   oor_now;
  logic [IDX_W-1:0]       idx_now;
  logic                   rd_en;
  logic [IDX_W-1:0]       rd_idx;
  logic                   rd_oor;
  logic [DATA_WIDTH-1:0]  mem_rdata;

  // The address is captured when the request leaves IDLE, so the initiator is
  // free to change instr_addr during the grant cycle.
  assign offset  = addr_q - BASE_ADDR;
  assign word    = offset >> 2;
  assign oor_now = (addr_q < BASE_ADDR) || (word >= ADDR_WIDTH'(MEM_DEPTH));
  assign idx_now = word[IDX_W-1:0];

  // Read strobe fires on the edge that enters RVALID.
  assign rd_en  = ((state_q == ST_GRANT) && RV_NOW) ||
                  ((state_q == ST_WAIT_RVALID) && (cnt_q == '0));
  assign rd_idx = (state_q == ST_GRANT) ? idx_now : idx_q;
  assign rd_oor = (state_q == ST_GRANT) ? oor_now : oor_q;

  instr_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk       (clk),
    .wr_en_i   (load_en),
    .wr_idx_i  (load_idx),
    .wr_data_i (load_data),
    .rd_en_i   (rd_en),
    .rd_idx_i  (rd_idx),
    .rd_data_o (mem_rdata)
  );

  // Handshake FSM with delay counter, protocol checker and response counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      idx_q        <= '0;
      oor_q        <= 1'b0;
      err_sel_q    <= 1'b0;
      have_data_q  <= 1'b0;
      grant_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      perr_q       <= 1'b0;
      resp_count_q <= '0;
    end else begin
      grant_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rsp_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (instr_req) begin
            addr_q <= instr_addr;
            if (!stall && GNT_NOW) begin
              state_q <= ST_GRANT;
              grant_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT_GNT;
              cnt_q   <= stall ? GNT_LD_STALL : GNT_LD_RUN;
            end
          end
        end

        ST_WAIT_GNT: begin
          if (!instr_req || (instr_addr != addr_q)) begin
            perr_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (!stall) begin
            if (cnt_q == '0) begin
              state_q <= ST_GRANT;
              grant_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end

        ST_GRANT: begin
          idx_q <= idx_now;
          oor_q <= oor_now;
          if (RV_NOW) begin
            state_q <= ST_RVALID;
          end else begin
            state_q <= ST_WAIT_RVALID;
            cnt_q   <= RV_LD;
          end
        end

        ST_WAIT_RVALID: begin
          if (cnt_q == '0) state_q <= ST_RVALID;
          else             cnt_q   <= cnt_q - 1'b1;
        end

        // A request present here is picked up by IDLE on the next cycle.
        ST_RVALID: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase

      if (rd_en) begin
        rvalid_q     <= 1'b1;
        rsp_err_q    <= rd_oor;
        err_sel_q    <= rd_oor;
        have_data_q  <= 1'b1;
        resp_count_q <= resp_count_q + 32'd1;
      end
    end
  end

  assign instr_grant  = grant_q;
  assign instr_rvalid = rvalid_q;
  assign rsp_err      = rsp_err_q;
  assign protocol_err = perr_q;
  assign resp_count   = resp_count_q;
  assign instr_rdata  = have_data_q ? (err_sel_q ? ERR_DATA : mem_rdata) : '0;

endmodule
